// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter plus APB master. One requester at a time is granted the
// shared APB bus; its command is latched at grant and driven through SETUP and
// ACCESS. A stalled slave is cut off after TIMEOUT wait cycles. The result is
// returned with a one-cycle ack pulse to the granted requester.
//
// Requester handshake: a requester raises req[i] with req_write/req_addr/
// req_wdata valid and keeps req[i] high until it sees ack[i] for one cycle;
// the command is captured at grant, so later changes on its inputs (including
// dropping req) do not affect the transfer already under way.
module apb_rr_master_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               ack,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             rsp_timeout,
    output logic [$clog2(NUM_REQ)-1:0]       gnt_id,
    output logic                             busy,
    output logic                             PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic [DATA_WIDTH-1:0]            PRDATA,
    input  logic                             PREADY,
    input  logic                             PSLVERR
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   winner;
    logic [CW-1:0]   wait_cnt;

    // Index base+k wrapped into 0..NUM_REQ-1 (k in 1..NUM_REQ).
    function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return GW'(s);
    endfunction

    // Round-robin pick: scan farthest-to-nearest so the nearest set bit after last_grant wins.
    always_comb begin
        winner = last_grant;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[wrap_idx(last_grant, k)]) winner = wrap_idx(last_grant, k);
        end
    end

    // Main FSM: arbitration, APB phase sequencing, timeout and response capture.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            last_grant  <= GW'(NUM_REQ - 1);
            wait_cnt    <= '0;
            ack         <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            gnt_id      <= '0;
            busy        <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state      <= SETUP;
                        PSEL       <= 1'b1;
                        busy       <= 1'b1;
                        PWRITE     <= req_write[winner];
                        PADDR      <= req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                        PWDATA     <= req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
                        gnt_id     <= winner;
                        last_grant <= winner;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        state       <= DONE;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        ack         <= NUM_REQ'(1) << gnt_id;
                        wait_cnt    <= '0;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= DONE;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        ack         <= NUM_REQ'(1) << gnt_id;
                        wait_cnt    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Bench for apb_rr_master_arbiter: directed requester traffic against a
// configurable APB slave model; responses are checked by a scoreboard.
module tb_apb_rr_master_arbiter;

    localparam int N  = 4;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int W  = 16;

    logic            PCLK = 1'b0;
    logic            PRESETn;
    logic [N-1:0]    req;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            rsp_timeout;
    logic [1:0]      gnt_id;
    logic            busy;
    logic            PSEL;
    logic            PENABLE;
    logic            PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [DW-1:0]   PRDATA;
    logic            PREADY;
    logic            PSLVERR;

    int            n_vec = 0;
    int            n_miss = 0;
    int            cyc = 0;
    logic [W-1:0]  exp_q[$];

    int            cfg_wait = 0;
    bit            cfg_stuck = 1'b0;
    logic [DW-1:0] cfg_rdata = '0;
    logic          cfg_err = 1'b0;

    apb_rr_master_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .gnt_id(gnt_id), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // Clock and cycle counter.
    initial forever begin
        #5 PCLK = ~PCLK;
        if (PCLK) cyc++;
    end

    function automatic logic [W-1:0] rsp(input logic [3:0] a, input logic [7:0] d,
                                         input logic e, input logic t, input logic [1:0] g);
        return {a, d, e, t, g};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]          = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req[i]                = 1'b1;
    endtask

    // Wait for ack[i], counting ACCESS cycles seen; drop req[i] on the ack.
    task automatic wait_ack(input int i, output int stamp, output int n_acc);
        int  b;
        bit  got;
        n_acc = 0;
        stamp = 0;
        got   = 1'b0;
        b     = 0;
        while (!got && b < 200) begin
            @(negedge PCLK);
            b++;
            if (PSEL && PENABLE) n_acc++;
            if (ack[i]) begin
                stamp  = cyc;
                req[i] = 1'b0;
                got    = 1'b1;
            end
        end
        if (!got) begin
            n_vec++;
            n_miss++;
            req[i] = 1'b0;
            $display("FAIL ack_wait: requester %0d saw no ack within 200 cycles, expected one", i);
        end
    endtask

    // Wait until the DUT is in ACCESS, bounded.
    task automatic wait_access();
        int b;
        b = 0;
        while (!(PSEL && PENABLE) && b < 50) begin
            @(negedge PCLK);
            b++;
        end
        check("reach_access", 32'(PSEL && PENABLE), 32'd1);
    endtask

    // APB slave model: PREADY rises after cfg_wait ACCESS cycles unless stuck.
    initial begin
        int k;
        k       = 0;
        PREADY  = 1'b0;
        PRDATA  = '0;
        PSLVERR = 1'b0;
        forever begin
            @(posedge PCLK);
            #1;
            PRDATA  = cfg_rdata;
            PSLVERR = cfg_err;
            if (PSEL && PENABLE) begin
                PREADY = !cfg_stuck && (k == cfg_wait);
                k++;
            end else begin
                k      = 0;
                PREADY = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every ack pops and compares one expected response.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge PCLK);
            if (PRESETn === 1'b1 && ack != '0) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_ack: got ack %b, expected no response", ack);
                end else begin
                    e = exp_q.pop_front();
                    check("response", 32'({ack, rsp_rdata, rsp_err, rsp_timeout, gnt_id}), 32'(e));
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        n_vec++;
        n_miss++;
        $display("FAIL watchdog: simulation still running at 200000, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Directed stimulus.
    initial begin
        int st[4];
        int s0, s3, na, bad, b;
        bit got;

        PRESETn   = 1'b0;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge PCLK);
        check("reset_rsp", 32'({ack, rsp_rdata, rsp_err, rsp_timeout, gnt_id, busy}), 32'd0);
        check("reset_apb", 32'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 32'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // 1: zero-wait write from requester 0.
        cfg_wait = 0;
        set_req(0, 1'b1, 9'h005, 8'hA5);
        exp_q.push_back(rsp(4'b0001, 8'h00, 1'b0, 1'b0, 2'd0));
        @(negedge PCLK);
        check("t1_setup_sel", 32'({PSEL, PENABLE}), 32'b10);
        check("t1_setup_cmd", 32'({PWRITE, PADDR, PWDATA}), 32'({1'b1, 9'h005, 8'hA5}));
        check("t1_busy_setup", 32'(busy), 32'd1);
        @(negedge PCLK);
        check("t1_access_sel", 32'({PSEL, PENABLE}), 32'b11);
        check("t1_busy_access", 32'(busy), 32'd1);
        wait_ack(0, s0, na);
        check("t1_ack_cycle_len", 32'(na), 32'd0);
        check("t1_busy_done", 32'({busy, PSEL, PENABLE}), 32'b100);
        @(negedge PCLK);
        check("t1_busy_idle", 32'(busy), 32'd0);

        // 2: read from requester 2 with two wait states.
        cfg_wait  = 2;
        cfg_rdata = 8'h3C;
        set_req(2, 1'b0, 9'h105, 8'h00);
        exp_q.push_back(rsp(4'b0100, 8'h3C, 1'b0, 1'b0, 2'd2));
        wait_ack(2, s0, na);
        check("t2_access_cycles", 32'(na), 32'd3);

        // 3: move pointer to 3, then all four requesters at once.
        cfg_wait  = 0;
        cfg_rdata = 8'h66;
        set_req(3, 1'b0, 9'h033, 8'h00);
        exp_q.push_back(rsp(4'b1000, 8'h66, 1'b0, 1'b0, 2'd3));
        wait_ack(3, s0, na);
        @(negedge PCLK);
        cfg_rdata = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1'b0, 9'(9'h010 + i), 8'h00);
            exp_q.push_back(rsp(4'(1 << i), 8'h5A, 1'b0, 1'b0, 2'(i)));
        end
        for (int i = 0; i < 4; i++) wait_ack(i, st[i], na);
        for (int i = 1; i < 4; i++) check("t3_ack_spacing", 32'(st[i] - st[i-1]), 32'd4);
        @(negedge PCLK);
        set_req(0, 1'b0, 9'h020, 8'h00);
        set_req(3, 1'b0, 9'h023, 8'h00);
        exp_q.push_back(rsp(4'b0001, 8'h5A, 1'b0, 1'b0, 2'd0));
        exp_q.push_back(rsp(4'b1000, 8'h5A, 1'b0, 1'b0, 2'd3));
        wait_ack(0, s0, na);
        wait_ack(3, s3, na);
        check("t3_regrant_spacing", 32'(s3 - s0), 32'd4);

        // 4: slave error on read, then timeout on write.
        cfg_rdata = 8'h77;
        cfg_err   = 1'b1;
        set_req(1, 1'b0, 9'h141, 8'h00);
        exp_q.push_back(rsp(4'b0010, 8'h77, 1'b1, 1'b0, 2'd1));
        wait_ack(1, s0, na);
        cfg_err   = 1'b0;
        cfg_stuck = 1'b1;
        set_req(2, 1'b1, 9'h0F0, 8'hC3);
        exp_q.push_back(rsp(4'b0100, 8'h00, 1'b1, 1'b1, 2'd2));
        wait_ack(2, s0, na);
        check("t4_timeout_cycles", 32'(na), 32'd16);
        cfg_stuck = 1'b0;

        // 5: reset during ACCESS of requester 1.
        cfg_wait = 3;
        set_req(1, 1'b0, 9'h1AB, 8'h00);
        wait_access();
        #2;
        PRESETn = 1'b0;
        #1;
        check("t5_reset_abort", 32'({PSEL, PENABLE, ack, busy, gnt_id}), 32'd0);
        set_req(3, 1'b0, 9'h1CD, 8'h00);
        @(negedge PCLK);
        cfg_wait  = 0;
        cfg_rdata = 8'h21;
        exp_q.push_back(rsp(4'b0010, 8'h21, 1'b0, 1'b0, 2'd1));
        exp_q.push_back(rsp(4'b1000, 8'h21, 1'b0, 1'b0, 2'd3));
        PRESETn = 1'b1;
        wait_ack(1, s0, na);
        wait_ack(3, s0, na);

        // 6: winner changes inputs and another requester arrives mid-transfer.
        cfg_wait  = 4;
        cfg_rdata = 8'h9E;
        set_req(0, 1'b1, 9'h0AA, 8'h42);
        exp_q.push_back(rsp(4'b0001, 8'h00, 1'b0, 1'b0, 2'd0));
        wait_access();
        req_addr[0 +: AW]  = 9'h1FF;
        req_wdata[0 +: DW] = 8'h00;
        req_write[0]       = 1'b0;
        set_req(2, 1'b0, 9'h122, 8'h00);
        exp_q.push_back(rsp(4'b0100, 8'h9E, 1'b0, 1'b0, 2'd2));
        bad = 0;
        got = 1'b0;
        b   = 0;
        while (!got && b < 50) begin
            @(negedge PCLK);
            b++;
            if ({PWRITE, PADDR, PWDATA} != {1'b1, 9'h0AA, 8'h42}) bad++;
            if (ack[0]) begin
                got    = 1'b1;
                req[0] = 1'b0;
            end
        end
        check("t6_ack0_seen", 32'(got), 32'd1);
        check("t6_cmd_held", 32'(bad), 32'd0);
        cfg_wait = 0;
        @(negedge PCLK);
        check("t6_idle_gap", 32'(PSEL), 32'd0);
        @(negedge PCLK);
        check("t6_next_grant", 32'({PSEL, PENABLE, gnt_id, PADDR}), 32'({1'b1, 1'b0, 2'd2, 9'h122}));
        wait_ack(2, s0, na);

        repeat (3) @(negedge PCLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/apb_rr_master_arbiter.md
Name: apb_rr_master_arbiter

Overview:
Round-robin arbiter and APB master that shares one APB bus (the APB slave wrapper) among NUM_REQ local requesters. It latches the winning request, runs the APB SETUP and ACCESS phases, and terminates stalled transfers with a PREADY timeout. It returns read data and error status to the winning requester with a one-cycle ack pulse. It sits between the requester/testbench side and the APB slave wrapper.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 9, PADDR width; the MSB selects the slave inside the wrapper
DATA_WIDTH, 8, PWDATA/PRDATA width
TIMEOUT, 16, number of consecutive ACCESS cycles with PREADY=0 before forced termination (>=2)

Ports:
PCLK  in  1  clock
PRESETn  in  1  reset, asynchronous, active-low
req  in  NUM_REQ  per-requester request; held high until its ack
req_write  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice i
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
ack  out  NUM_REQ  one-hot completion pulse
rsp_rdata  out  DATA_WIDTH  read data; valid while ack is high
rsp_err  out  1  PSLVERR or timeout; valid while ack is high
rsp_timeout  out  1  set when the transfer ended by timeout; valid while ack is high
gnt_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
busy  out  1  high in SETUP, ACCESS and DONE
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - All outputs are 0. PADDR, PWDATA, rsp_rdata and gnt_id are 0.
  - last_grant = NUM_REQ-1, so requester 0 has highest priority first.
  - The timeout counter is 0.
  - Reset mid-transfer aborts the transfer immediately with no ack. The aborted request is not remembered.
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- IDLE:
  - If req != 0, pick the winner as the first set bit searching from last_grant+1 upward, wrapping.
  - Latch that requester's write, address and wdata into PWRITE/PADDR/PWDATA.
  - Set gnt_id and last_grant to the winner. Next state is SETUP.
  - Otherwise stay in IDLE.
- SETUP: PSEL=1, PENABLE=0. Always goes to ACCESS next.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1: capture rsp_rdata = PWRITE ? 0 : PRDATA, rsp_err = PSLVERR, rsp_timeout = 0. Next state is DONE.
  - PREADY=0: increment the counter. When it reaches TIMEOUT, go to DONE with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - The counter clears on leaving ACCESS.
- DONE:
  - PSEL=0, PENABLE=0; ack[gnt_id]=1 for exactly this cycle.
  - Next state is always IDLE. No arbitration happens in DONE, so a requester can drop req after seeing ack without being regranted.
  - rsp_* hold their values until the next DONE.
- PWRITE, PADDR and PWDATA are stable from SETUP through the end of ACCESS. They hold their last values in IDLE/DONE and change only at a grant.
- Requests withdrawn after grant are ignored; the latched transfer completes.
- Changes on req_addr, req_wdata or req_write of the winner during a transfer are ignored.
- Simultaneous requests: exactly one grant per arbitration. Starvation-free; worst-case wait is NUM_REQ-1 transfers.
- Zero-wait transfer takes 4 cycles (IDLE, SETUP, ACCESS, DONE). Each PREADY=0 cycle adds one.
- PSLVERR is only sampled in ACCESS with PREADY=1.

Test Plan:
1. Reset, then a write from req[0] (addr 9'h005, data 8'hA5) with PREADY=1:
   - Required: SETUP one cycle later with PSEL=1, PENABLE=0, PADDR=005, PWRITE=1; next cycle PENABLE=1.
   - Required: ack=4'b0001 on the following cycle with rsp_err=0; busy high for 3 cycles.
2. Read from req[2] (addr 9'h105) with PRDATA=8'h3C and PREADY low for 2 ACCESS cycles:
   - Required: ACCESS lasts 3 cycles; ack=4'b0100, rsp_rdata=3C, gnt_id=2.
3. req=4'b1111 held, with each requester dropping its req after its own ack:
   - Required: grant order 0,1,2,3, each with one IDLE cycle between transfers.
   - Then req[0] and req[3] re-asserted: next grant is 0, then 3.
4. Read with PSLVERR=1 and PREADY=1, then a write with PREADY stuck at 0:
   - Required: first response rsp_err=1, rsp_timeout=0.
   - Required: the second terminates after exactly 16 ACCESS cycles with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
5. PRESETn pulsed low during ACCESS of req[1]:
   - Required: PSEL, PENABLE and ack go 0 immediately.
   - Required: after release, with req[1] and req[3] both high, requester 1 is granted first.
6. The winner changes req_addr, and another requester raises req, during a wait-stated ACCESS:
   - Required: PADDR stays unchanged.
   - Required: the new requester is granted only after DONE and IDLE.
